regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, >=2).
REQ-003 SHALL have parameter AW, default $clog2(NREG), meaning register address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports ra1, ra2  input  AW  read addresses.
REQ-007 SHALL have ports rd1, rd2  output  DW  read data (combinational).
REQ-008 SHALL have ports rb1, rb2  output  1  read register busy (write pending).
REQ-009 SHALL have ports we (input 1), wa (input AW), wd (input DW)  writeback enable, address, data.
REQ-010 SHALL have ports iss (input 1), iss_rd (input AW)  issue enable, destination to mark busy.
REQ-011 SHALL have port wr_cnt  output  32  count of committed writes to nonzero registers.

Function
REQ-012 SHALL hold register 0 at constant zero: writes to it are ignored, it is never busy, and it never counts.
REQ-013 SHALL, on rising clk with we=1 and wa!=0, store wd in register wa, clear busy[wa], and increment wr_cnt by 1.
REQ-014 SHALL provide read data with zero-cycle latency: rdN = reg[raN], or 0 when raN==0.
REQ-015 SHALL, with bypass compiled in, drive rdN=wd and rbN=0 in the same cycle when we=1, wa==raN and wa!=0.
REQ-016 SHALL, on rising clk with iss=1 and iss_rd!=0, set busy[iss_rd].
REQ-017 SHALL, when iss and we target the same nonzero register in one cycle, write the data and leave busy set (issue wins).
REQ-018 SHALL allow iss and we on different registers in one cycle with both effects applied.
REQ-019 SHALL drive rbN = busy[raN], except per REQ-012 and REQ-015.
REQ-020 SHALL wrap wr_cnt from 0xFFFFFFFF to 0 without a flag.
REQ-021 SHALL ignore a write to a register that is not busy for busy purposes only; the data still commits.

Reset
REQ-022 SHALL, on rising clk with rst=1, clear all registers, all busy bits and wr_cnt to 0, overriding a simultaneous we or iss.
REQ-023 SHALL, after reset, read rd1=rd2=0, rb1=rb2=0 and wr_cnt=0 for every address.
REQ-024 SHALL discard any pending writeback and issue when rst is asserted mid-operation; it SHALL NOT produce partial updates.

Configuration
REQ-025 SHALL, when macro REGFILE_SB_BYPASS_EN is defined, implement write-to-read forwarding per REQ-015.
REQ-026 SHALL, when REGFILE_SB_BYPASS_EN is undefined, return the pre-write stored value and the current busy bit in the write cycle, with new data visible the next cycle.

Structure
REQ-027 SHALL take default DW/NREG constants and the zero-register index from shared package regfile_pkg.
REQ-028 SHALL isolate busy-bit tracking (set/clear/priority) in sub-module rf_scoreboard; storage and read muxing SHALL remain in regfile_sb.

Verification
REQ-029 SHALL verify: rst pulse, then read all 32 addresses -> every rdN=0, rbN=0, wr_cnt=0.
REQ-030 SHALL verify: we=1, wa=5, wd=0xDEADBEEF; next cycle ra1=5 -> rd1=0xDEADBEEF, wr_cnt=1.
REQ-031 SHALL verify: we=1, wa=0, wd=0x12345678 -> rd1 at ra1=0 is 0, wr_cnt unchanged.
REQ-032 SHALL verify: iss_rd=7, then ra2=7 -> rb2=1; with bypass, we to 7 with wd=0xA5 -> same cycle rd2=0xA5, rb2=0; without bypass -> rd2=old value, rb2=1 that cycle.
REQ-033 SHALL verify: iss and we both target register 9, wd=0x55 -> next cycle rd1=0x55, rb1=1.
REQ-034 SHALL verify: preload wr_cnt to 0xFFFFFFFF via writes and force, then one write -> wr_cnt=0; rst asserted with we=1 -> target register stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its scoreboard.
// Holds default geometry and the hardwired zero-register index.
package regfile_pkg;

  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  // True when an address names the hardwired zero register.
  function automatic logic is_zero_reg(input int unsigned a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, writeback clears it.
// Ports: clk, rst (sync, active-high), we/wa writeback, iss/iss_rd issue,
//        busy_o = one pending bit per register (bit 0 always clear).
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic            iss_i,
  input  logic [AW-1:0]   iss_rd_i,
  output logic [NREG-1:0] busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic clr_hit;
  logic set_hit;

  assign clr_hit = we_i  && (wa_i     != AW'(ZERO_REG));
  assign set_hit = iss_i && (iss_rd_i != AW'(ZERO_REG));

  // Clear first, set second: an issue to the register being written
  // back in the same cycle leaves it pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_hit) busy_d[wa_i] = 1'b0;
    if (set_hit) busy_d[iss_rd_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with zero register, two async read ports and a scoreboard.
// Ports: clk, rst (sync, active-high); ra1/ra2 -> rd1/rd2 data, rb1/rb2 busy;
//        we/wa/wd writeback; iss/iss_rd issue; wr_cnt committed-write count.
// Build option: define REGFILE_SB_BYPASS_EN to forward writeback data
// and a cleared busy bit to a read of the same register in the write cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rb1,
  output logic          rb2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          iss,
  input  logic [AW-1:0] iss_rd,
  output logic [31:0]   wr_cnt
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [31:0]     wr_cnt_q;
  logic [31:0]     wr_cnt_d;
  logic [NREG-1:0] busy;
  logic            wr_hit;
  logic            byp1;
  logic            byp2;

  assign wr_hit = we && (wa != AW'(ZERO_REG));

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .wa_i     (wa),
    .iss_i    (iss),
    .iss_rd_i (iss_rd),
    .busy_o   (busy)
  );

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_hit) regs_d[wa] = wd;
    regs_d[ZERO_REG] = '0;
  end

  // Counter wraps naturally at 2^32.
  assign wr_cnt_d = wr_hit ? wr_cnt_q + 32'd1 : wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef REGFILE_SB_BYPASS_EN
  assign byp1 = wr_hit && (wa == ra1);
  assign byp2 = wr_hit && (wa == ra2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rd1 = regs_q[ra1];
    rb1 = busy[ra1];
    if (byp1) begin
      rd1 = wd;
      rb1 = 1'b0;
    end
    if (is_zero_reg(32'(ra1))) begin
      rd1 = '0;
      rb1 = 1'b0;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    rb2 = busy[ra2];
    if (byp2) begin
      rd2 = wd;
      rb2 = 1'b0;
    end
    if (is_zero_reg(32'(ra2))) begin
      rd2 = '0;
      rb2 = 1'b0;
    end
  end

  assign wr_cnt = wr_cnt_q;

endmodule
